// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared types and constants for the byte-stream program loader.
//   state_e   : loader FSM states
//   CMD_*     : command byte values recognised in IDLE
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  localparam logic [7:0] CMD_IMEM  = 8'h01;
  localparam logic [7:0] CMD_DMEM  = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;

endpackage : prog_loader_pkg

// File: rtl/prog_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Collects four accepted bytes into a little-endian 32-bit word.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   byte_i        : incoming byte
//   byte_valid_i  : byte is accepted this cycle
//   word_valid_o  : this cycle's byte completes a word (combinational)
//   word_o        : the completed word, valid while word_valid_o is high
// Only the first three bytes are stored; the fourth is taken straight from
// byte_i so the caller can register the word in the same cycle.
// -----------------------------------------------------------------------------
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;

  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (byte_valid_i) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
    end
  end

  assign word_valid_o = byte_valid_i && (lane_q == 2'd3);
  assign word_o       = {byte_i, shift_q};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational blocks use blocking assignments.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule : word_assembler

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a framed byte stream and writes instruction words / data bytes,
// then releases the CPU on a START command.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   rx_data_i/rx_valid_i   : stream byte in; rx_ready_o accepts it
//   imem_we_o/addr/data    : one-cycle instruction word write
//   dmem_we_o/addr/data    : one-cycle data byte write
//   cpu_start_o            : CPU start level, held until reset
//   busy_o                 : frame in progress or write pending
//   err_o                  : sticky unknown-command flag
// Frames: 01 ADDR COUNT 4*N bytes | 02 ADDR COUNT N bytes | 03 ; COUNT 0 = 256.
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter  int IMEM_WORDS = 256,
  parameter  int DMEM_BYTES = 32,
  localparam int IMEM_AW    = $clog2(IMEM_WORDS),
  localparam int DMEM_AW    = $clog2(DMEM_BYTES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  output logic               rx_ready_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_data_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [7:0]         dmem_data_o,
  output logic               cpu_start_o,
  output logic               busy_o,
  output logic               err_o
);

  state_e state_q, state_d;

  logic               imem_sel_q, imem_sel_d;   // 1: current frame targets imem
  logic [IMEM_AW-1:0] imem_ptr_q, imem_ptr_d;
  logic [DMEM_AW-1:0] dmem_ptr_q, dmem_ptr_d;
  // Remaining data bytes minus one; 1024 bytes fit in 10 bits this way.
  logic [9:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               start_q, start_d;

  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]        imem_data_q, imem_data_d;
  logic               dmem_we_q, dmem_we_d;
  logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
  logic [7:0]         dmem_data_q, dmem_data_d;

  logic        hs;
  logic        asm_valid;
  logic        word_valid;
  logic [31:0] word;
  logic [7:0]  count_m1;

  assign rx_ready_o = (state_q != ST_RUN);
  assign hs         = rx_valid_i && rx_ready_o;
  assign asm_valid  = hs && (state_q == ST_DATA) && imem_sel_q;
  assign count_m1   = rx_data_i - 8'd1;   // COUNT 0 wraps to 255 -> 256 items

  word_assembler u_word_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_i       (rx_data_i),
    .byte_valid_i (asm_valid),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d     = state_q;
    imem_sel_d  = imem_sel_q;
    imem_ptr_d  = imem_ptr_q;
    dmem_ptr_d  = dmem_ptr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    start_d     = start_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    dmem_we_d   = 1'b0;
    dmem_addr_d = dmem_addr_q;
    dmem_data_d = dmem_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          case (rx_data_i)
            CMD_IMEM: begin
              imem_sel_d = 1'b1;
              state_d    = ST_ADDR;
            end
            CMD_DMEM: begin
              imem_sel_d = 1'b0;
              state_d    = ST_ADDR;
            end
            CMD_START: begin
              start_d = 1'b1;
              state_d = ST_RUN;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_ADDR: begin
        if (hs) begin
          imem_ptr_d = IMEM_AW'(rx_data_i);
          dmem_ptr_d = DMEM_AW'(rx_data_i);
          state_d    = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (hs) begin
          cnt_d   = imem_sel_q ? {count_m1, 2'b11} : {2'b00, count_m1};
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (hs) begin
          if (imem_sel_q) begin
            if (word_valid) begin
              imem_we_d   = 1'b1;
              imem_addr_d = imem_ptr_q;
              imem_data_d = word;
              imem_ptr_d  = imem_ptr_q + IMEM_AW'(1);
            end
          end else begin
            dmem_we_d   = 1'b1;
            dmem_addr_d = dmem_ptr_q;
            dmem_data_d = rx_data_i;
            dmem_ptr_d  = dmem_ptr_q + DMEM_AW'(1);
          end
          if (cnt_q == 10'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 10'd1;
          end
        end
      end

      ST_RUN: ;   // terminal until reset

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      imem_sel_q  <= 1'b0;
      imem_ptr_q  <= '0;
      dmem_ptr_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      dmem_data_q <= '0;
    end else begin
      state_q     <= state_d;
      imem_sel_q  <= imem_sel_d;
      imem_ptr_q  <= imem_ptr_d;
      dmem_ptr_q  <= dmem_ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      start_q     <= start_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      dmem_we_q   <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_data_q <= dmem_data_d;
    end
  end

  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_data_o = imem_data_q;
  assign dmem_we_o   = dmem_we_q;
  assign dmem_addr_o = dmem_addr_q;
  assign dmem_data_o = dmem_data_q;
  assign cpu_start_o = start_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q == ST_ADDR) || (state_q == ST_COUNT) ||
                       (state_q == ST_DATA) || imem_we_q || dmem_we_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Drives framed byte streams into prog_loader and compares every memory write
// against a list of writes computed directly from each frame's address, count
// and payload.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int IMEM_AW = 8;
  localparam int DMEM_AW = 5;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [7:0]         rx_data_i = 8'h00;
  logic               rx_valid_i = 1'b0;
  logic               rx_ready_o;
  logic               imem_we_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_data_o;
  logic               dmem_we_o;
  logic [DMEM_AW-1:0] dmem_addr_o;
  logic [7:0]         dmem_data_o;
  logic               cpu_start_o;
  logic               busy_o;
  logic               err_o;

  prog_loader dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_o (imem_data_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_addr_o (dmem_addr_o),
    .dmem_data_o (dmem_data_o),
    .cpu_start_o (cpu_start_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  bit gaps     = 1'b0;

  logic [39:0] imem_exp[$];
  logic [39:0] imem_got[$];
  logic [12:0] dmem_exp[$];
  logic [12:0] dmem_got[$];
  logic [7:0]  pl[$];

  // Outputs are registered, so the falling edge sees them settled.
  always @(negedge clk_i) begin
    if (imem_we_o) imem_got.push_back({imem_addr_o, imem_data_o});
    if (dmem_we_o) dmem_got.push_back({dmem_addr_o, dmem_data_o});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        @(posedge clk_i);
        #1;
      end
    end
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  // Frame senders: the expected writes follow directly from the frame fields.
  task automatic send_imem(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d[$]);
    int n;
    n = (c == 8'd0) ? 256 : int'(c);
    for (int i = 0; i < n; i++)
      imem_exp.push_back({8'((int'(a) + i) % 256),
                          d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
    send_byte(8'h01);
    send_byte(a);
    send_byte(c);
    for (int i = 0; i < 4*n; i++) send_byte(d[i]);
  endtask

  task automatic send_dmem(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d[$]);
    int n;
    n = (c == 8'd0) ? 256 : int'(c);
    for (int i = 0; i < n; i++)
      dmem_exp.push_back({5'((int'(a) + i) % 32), d[i]});
    send_byte(8'h02);
    send_byte(a);
    send_byte(c);
    for (int i = 0; i < n; i++) send_byte(d[i]);
  endtask

  task automatic rand_payload(input int n);
    pl = {};
    repeat (n) pl.push_back(8'($urandom));
  endtask

  task automatic settle_and_compare(input string tag);
    int m;
    repeat (4) @(posedge clk_i);
    #1;
    check({tag, "_imem_count"}, imem_got.size(), imem_exp.size());
    m = (imem_got.size() < imem_exp.size()) ? imem_got.size() : imem_exp.size();
    for (int i = 0; i < m; i++) check({tag, "_imem_write"}, imem_got[i], imem_exp[i]);
    check({tag, "_dmem_count"}, dmem_got.size(), dmem_exp.size());
    m = (dmem_got.size() < dmem_exp.size()) ? dmem_got.size() : dmem_exp.size();
    for (int i = 0; i < m; i++) check({tag, "_dmem_write"}, dmem_got[i], dmem_exp[i]);
    check({tag, "_busy_idle"}, busy_o, 1'b0);
    imem_exp = {}; imem_got = {};
    dmem_exp = {}; dmem_got = {};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, rx_ready_o, 1'b1);
    check({tag, "_imem_we"},  imem_we_o, 1'b0);
    check({tag, "_dmem_we"},  dmem_we_o, 1'b0);
    check({tag, "_imem_out"}, {imem_addr_o, imem_data_o}, 40'h0);
    check({tag, "_dmem_out"}, {dmem_addr_o, dmem_data_o}, 13'h0);
    check({tag, "_start"},    cpu_start_o, 1'b0);
    check({tag, "_busy"},     busy_o, 1'b0);
    check({tag, "_err"},      err_o, 1'b0);
  endtask

  task automatic tests_1_to_3(input string tag);
    int c;
    // Test 1: single instruction word.
    pl = {8'h05, 8'h00, 8'h08, 8'h20};
    send_imem(8'h00, 8'h01, pl);
    settle_and_compare({tag, "t1"});
    check({tag, "t1_word_const"}, {imem_addr_o, imem_data_o}, {8'h00, 32'h20080005});
    check({tag, "t1_err"}, err_o, 1'b0);
    // Test 2: single byte, then a two-byte write that wraps at 31.
    pl = {8'h05};
    send_dmem(8'h00, 8'h01, pl);
    pl = {8'hAA, 8'hBB};
    send_dmem(8'h1F, 8'h02, pl);
    settle_and_compare({tag, "t2"});
    // Test 3: word-address wrap, then COUNT 0 (256 words).
    pl = {8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
    send_imem(8'hFF, 8'h02, pl);
    settle_and_compare({tag, "t3_wrap"});
    rand_payload(1024);
    send_imem(8'($urandom), 8'h00, pl);
    settle_and_compare({tag, "t3_full"});
    // Random back-to-back frames of both kinds.
    repeat (6) begin
      c = $urandom_range(1, 40);
      if ($urandom_range(0, 1) == 1) begin
        rand_payload(4*c);
        send_imem(8'($urandom), 8'(c), pl);
      end else begin
        rand_payload(c);
        send_dmem(8'($urandom), 8'(c), pl);
      end
    end
    settle_and_compare({tag, "rand"});
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    tests_1_to_3("a_");

    // Test 4: unknown command sets a sticky error and is otherwise ignored.
    send_byte(8'h7E);
    check("t4_err_set", err_o, 1'b1);
    check("t4_busy", busy_o, 1'b0);
    pl = {8'h05, 8'h00, 8'h08, 8'h20};
    send_imem(8'h00, 8'h01, pl);
    settle_and_compare("t4");
    check("t4_err_sticky", err_o, 1'b1);

    // Test 5: START releases the CPU and locks out the stream.
    check("t5_start_before", cpu_start_o, 1'b0);
    send_byte(8'h03);
    check("t5_start", cpu_start_o, 1'b1);
    check("t5_ready", rx_ready_o, 1'b0);
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h05);
    settle_and_compare("t5_locked");
    check("t5_start_held", cpu_start_o, 1'b1);
    check("t5_ready_held", rx_ready_o, 1'b0);

    // Test 6: reset from RUN, then reset mid-frame.
    #2 rst_i = 1'b1;
    #1;
    check_reset_outputs("t6_run_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h05); send_byte(8'h00);
    check("t6_busy_mid", busy_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check_reset_outputs("t6_mid_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    settle_and_compare("t6_discard");
    pl = {8'h05, 8'h00, 8'h08, 8'h20};
    send_imem(8'h00, 8'h01, pl);
    settle_and_compare("t6_clean");

    gaps = 1'b1;
    tests_1_to_3("g_");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_prog_loader
